// File: rtl/mc_datapath.sv
// Multi-cycle RV32 datapath: FETCH/DECODE/EXEC/MEM/WB with req/ready memory handshakes.
// Optional MC_PERF_CNT_EN adds 64-bit cycle_cnt/instret_cnt outputs.
// alu_controls: 0 ADD 1 SUB 2 SLL 3 SLT 4 SLTU 5 XOR 6 SRL 7 SRA 8 OR 9 AND,
//               10 BEQ 11 BNE 12 BLT 13 BGE 14 BLTU 15 BGEU (compare A with the ALU B operand).
module mc_datapath #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned NREGS    = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  alu_controls,
    input  logic        reg_wr_en,
    input  logic        aluSrcMuxSel,
    input  logic        branch,
    input  logic        jal,
    input  logic        jalr,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [2:0]  RegWdataSel,
    output logic [31:0] instr_code,
    output logic        imem_req,
    input  logic        imem_ready,
    output logic [31:0] instr_rAddr,
    input  logic [31:0] imem_rdata,
    output logic        dmem_req,
    input  logic        dmem_ready,
    output logic        dmem_we,
    output logic [31:0] dAddr,
    output logic [31:0] dWdata,
    input  logic [31:0] dRdata,
`ifdef MC_PERF_CNT_EN
    output logic [63:0] cycle_cnt,
    output logic [63:0] instret_cnt,
`endif
    output logic        illegal_reg
);
    localparam int unsigned IdxW = $clog2(NREGS);

    typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d, imm_q, imm_d;
    logic [31:0] alu_out_q, alu_out_d, mdr_q, mdr_d;
    logic        b_taken_q, b_taken_d, illegal_q, illegal_d;
    logic [31:0] regs_q [NREGS];

    logic [6:0]  opcode;
    logic [4:0]  rs1, rs2, rd;
    logic        rs1_bad, rs2_bad, rd_bad, uses_rs1, uses_rs2, rf_we;
    logic [31:0] rs1_val, rs2_val, imm_dec, alu_b, alu_res, wb_data, pc_plus4, target;
    logic        cmp;

    assign opcode   = ir_q[6:0];
    assign rs1      = ir_q[19:15];
    assign rs2      = ir_q[24:20];
    assign rd       = ir_q[11:7];
    assign rs1_bad  = 32'(rs1) >= NREGS;
    assign rs2_bad  = 32'(rs2) >= NREGS;
    assign rd_bad   = 32'(rd) >= NREGS;
    assign uses_rs1 = !(opcode inside {7'b0110111, 7'b0010111, 7'b1101111});
    assign uses_rs2 = opcode inside {7'b0110011, 7'b0100011, 7'b1100011};
    assign pc_plus4 = pc_q + 32'd4;
    assign target   = pc_q + imm_q;
    assign alu_b    = aluSrcMuxSel ? imm_q : b_q;
    assign rf_we    = (state_q == StWb) && reg_wr_en && (rd != 5'd0) && !rd_bad;

    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        if (rs1 != 5'd0 && !rs1_bad) rs1_val = regs_q[rs1[IdxW-1:0]];
        if (rs2 != 5'd0 && !rs2_bad) rs2_val = regs_q[rs2[IdxW-1:0]];
    end

    always_comb begin
        case (opcode)
            7'b0100011: imm_dec = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
            7'b1100011: imm_dec = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
            7'b0110111, 7'b0010111: imm_dec = {ir_q[31:12], 12'b0};
            7'b1101111: imm_dec = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
            default:    imm_dec = {{20{ir_q[31]}}, ir_q[31:20]};
        endcase
    end

    always_comb begin
        case (alu_controls)
            4'd0:    alu_res = a_q + alu_b;
            4'd1:    alu_res = a_q - alu_b;
            4'd2:    alu_res = a_q << alu_b[4:0];
            4'd3:    alu_res = {31'b0, $signed(a_q) < $signed(alu_b)};
            4'd4:    alu_res = {31'b0, a_q < alu_b};
            4'd5:    alu_res = a_q ^ alu_b;
            4'd6:    alu_res = a_q >> alu_b[4:0];
            4'd7:    alu_res = $signed(a_q) >>> alu_b[4:0];
            4'd8:    alu_res = a_q | alu_b;
            4'd9:    alu_res = a_q & alu_b;
            default: alu_res = a_q - alu_b;
        endcase
        case (alu_controls)
            4'd10:   cmp = a_q == alu_b;
            4'd11:   cmp = a_q != alu_b;
            4'd12:   cmp = $signed(a_q) < $signed(alu_b);
            4'd13:   cmp = $signed(a_q) >= $signed(alu_b);
            4'd14:   cmp = a_q < alu_b;
            4'd15:   cmp = a_q >= alu_b;
            default: cmp = 1'b0;
        endcase
    end

    always_comb begin
        case (RegWdataSel)
            3'd1:    wb_data = mdr_q;
            3'd2:    wb_data = imm_q;
            3'd3:    wb_data = target;
            3'd4:    wb_data = pc_plus4;
            default: wb_data = alu_out_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        imm_d     = imm_q;
        alu_out_d = alu_out_q;
        b_taken_d = b_taken_q;
        mdr_d     = mdr_q;
        illegal_d = illegal_q;
        case (state_q)
            StFetch: begin
                if (imem_ready) begin
                    ir_d    = imem_rdata;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                a_d       = rs1_val;
                b_d       = rs2_val;
                imm_d     = imm_dec;
                illegal_d = illegal_q | (uses_rs1 & rs1_bad) | (uses_rs2 & rs2_bad);
                state_d   = StExec;
            end
            StExec: begin
                alu_out_d = alu_res;
                b_taken_d = cmp;
                state_d   = (mem_rd || mem_wr) ? StMem : StWb;
            end
            StMem: begin
                if (dmem_ready) begin
                    if (!mem_wr) mdr_d = dRdata;
                    state_d = StWb;
                end
            end
            StWb: begin
                if (jalr)                      pc_d = (a_q + imm_q) & ~32'h1;
                else if (jal || (branch && b_taken_q)) pc_d = target;
                else                           pc_d = pc_plus4;
                illegal_d = illegal_q | (reg_wr_en & rd_bad);
                state_d   = StFetch;
            end
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StFetch;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            imm_q     <= '0;
            alu_out_q <= '0;
            b_taken_q <= 1'b0;
            mdr_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            imm_q     <= imm_d;
            alu_out_q <= alu_out_d;
            b_taken_q <= b_taken_d;
            mdr_q     <= mdr_d;
            illegal_q <= illegal_d;
        end
    end

    // GPRs are deliberately left unreset; x0 is never written and always reads as zero.
    always_ff @(posedge clk) begin
        if (!reset && rf_we) regs_q[rd[IdxW-1:0]] <= wb_data;
    end

`ifdef MC_PERF_CNT_EN
    logic [63:0] cycle_cnt_q, instret_cnt_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
        end else begin
            cycle_cnt_q   <= cycle_cnt_q + 64'd1;
            instret_cnt_q <= instret_cnt_q + {63'b0, state_q == StWb};
        end
    end
    assign cycle_cnt   = cycle_cnt_q;
    assign instret_cnt = instret_cnt_q;
`endif

    assign imem_req    = (state_q == StFetch) && !reset;
    assign dmem_req    = (state_q == StMem) && !reset;
    assign dmem_we     = dmem_req && mem_wr;
    assign instr_code  = ir_q;
    assign instr_rAddr = pc_q;
    assign dAddr       = alu_out_q;
    assign dWdata      = b_q;
    assign illegal_reg = illegal_q;
endmodule

// File: tb/tb_mc_datapath.sv
// Scoreboard bench for mc_datapath: expected fetch/data transactions are queued with the
// program and checked as the memory models complete each handshake.
`timescale 1ns/1ps
module tb_mc_datapath;
    localparam logic [31:0] RstPc = 32'h100;
    localparam int unsigned DDly  = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  alu_controls;
    logic        reg_wr_en, aluSrcMuxSel, branch, jal, jalr, mem_rd, mem_wr;
    logic [2:0]  RegWdataSel;
    logic [31:0] instr_code, instr_rAddr, imem_rdata, dAddr, dWdata, dRdata;
    logic        imem_req, imem_ready, dmem_req, dmem_ready, dmem_we, illegal_reg;
`ifdef MC_PERF_CNT_EN
    logic [63:0] cycle_cnt, instret_cnt;
`endif

    always #5 clk = ~clk;

    mc_datapath #(.RESET_PC(RstPc), .NREGS(16)) u_dut (
        .clk(clk), .reset(reset), .alu_controls(alu_controls), .reg_wr_en(reg_wr_en),
        .aluSrcMuxSel(aluSrcMuxSel), .branch(branch), .jal(jal), .jalr(jalr),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .RegWdataSel(RegWdataSel),
        .instr_code(instr_code), .imem_req(imem_req), .imem_ready(imem_ready),
        .instr_rAddr(instr_rAddr), .imem_rdata(imem_rdata), .dmem_req(dmem_req),
        .dmem_ready(dmem_ready), .dmem_we(dmem_we), .dAddr(dAddr), .dWdata(dWdata),
        .dRdata(dRdata),
`ifdef MC_PERF_CNT_EN
        .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt),
`endif
        .illegal_reg(illegal_reg)
    );

    // Reference control unit decoding the IR.
    always_comb begin
        alu_controls = 4'd0; reg_wr_en = 1'b0; aluSrcMuxSel = 1'b0; branch = 1'b0;
        jal = 1'b0; jalr = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; RegWdataSel = 3'd0;
        case (instr_code[6:0])
            7'b0010011: begin reg_wr_en = 1'b1; aluSrcMuxSel = 1'b1; end
            7'b0000011: begin
                reg_wr_en = 1'b1; aluSrcMuxSel = 1'b1; mem_rd = 1'b1; RegWdataSel = 3'd1;
            end
            7'b0100011: begin aluSrcMuxSel = 1'b1; mem_wr = 1'b1; end
            7'b1100011: begin
                branch = 1'b1;
                case (instr_code[14:12])
                    3'b001:  alu_controls = 4'd11;
                    3'b100:  alu_controls = 4'd12;
                    3'b101:  alu_controls = 4'd13;
                    3'b110:  alu_controls = 4'd14;
                    3'b111:  alu_controls = 4'd15;
                    default: alu_controls = 4'd10;
                endcase
            end
            7'b1101111: begin jal = 1'b1; reg_wr_en = 1'b1; RegWdataSel = 3'd4; end
            7'b1100111: begin jalr = 1'b1; reg_wr_en = 1'b1; RegWdataSel = 3'd4; end
            default: ;
        endcase
    end

    typedef struct { logic [31:0] addr; int unsigned gap; logic ill; } fetch_t;
    typedef struct { logic [31:0] addr; logic we; logic [31:0] data; } dacc_t;

    logic [31:0] imem [logic [31:0]];
    int unsigned idly [logic [31:0]];
    logic [31:0] dmem [logic [31:0]];
    fetch_t      fq[$];
    dacc_t       dq[$];

    int          checks = 0, errors = 0;
    int unsigned cyc = 0, last_fcyc = 0, iwait = 0, dwait = 0;
    logic [31:0] cap_pc, cap_ir, cap_da, cap_dw;
    logic        cap_we;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    // Place an instruction and queue its expected fetch (gap 0 = not checked).
    task automatic put(input logic [31:0] addr, input logic [31:0] ins, input int unsigned dly,
                       input int unsigned gap, input logic ill);
        fetch_t f;
        imem[addr] = ins;
        idly[addr] = dly;
        f.addr = addr; f.gap = gap; f.ill = ill;
        fq.push_back(f);
    endtask
    task automatic exp_d(input logic [31:0] addr, input logic we, input logic [31:0] data);
        dacc_t d;
        d.addr = addr; d.we = we; d.data = data;
        dq.push_back(d);
    endtask

    task automatic bus_step();
        fetch_t      f;
        dacc_t       d;
        int unsigned dly;
        cyc++;
        if (imem_req) begin
            if (iwait == 0) begin
                cap_pc = instr_rAddr; cap_ir = instr_code;
            end else begin
                check_eq("fetch_addr_stable", instr_rAddr, cap_pc);
                check_eq("ir_stable", instr_code, cap_ir);
            end
            dly = idly.exists(instr_rAddr) ? idly[instr_rAddr] : 0;
            if (iwait < dly) begin
                imem_ready = 1'b0;
                iwait++;
            end else begin
                imem_ready = 1'b1;
                imem_rdata = imem.exists(instr_rAddr) ? imem[instr_rAddr] : 32'h0000_0013;
                iwait = 0;
                check_eq("fetch_expected", 32'(fq.size() != 0), 32'd1);
                if (fq.size() != 0) begin
                    f = fq.pop_front();
                    check_eq("fetch_addr", instr_rAddr, f.addr);
                    check_eq("illegal_reg", 32'(illegal_reg), 32'(f.ill));
                    if (f.gap != 0) check_eq("fetch_gap", cyc - last_fcyc, f.gap);
                end
                last_fcyc = cyc;
            end
        end else begin
            imem_ready = 1'b0;
            iwait = 0;
        end
        if (dmem_req) begin
            if (dwait == 0) begin
                cap_da = dAddr; cap_dw = dWdata; cap_we = dmem_we;
            end else begin
                check_eq("daddr_stable", dAddr, cap_da);
                check_eq("dwdata_stable", dWdata, cap_dw);
                check_eq("dwe_stable", 32'(dmem_we), 32'(cap_we));
            end
            if (dwait < DDly) begin
                dmem_ready = 1'b0;
                dwait++;
            end else begin
                dmem_ready = 1'b1;
                dwait = 0;
                check_eq("dacc_expected", 32'(dq.size() != 0), 32'd1);
                if (dq.size() != 0) begin
                    d = dq.pop_front();
                    check_eq("daddr", dAddr, d.addr);
                    check_eq("dmem_we", 32'(dmem_we), 32'(d.we));
                    if (d.we) check_eq("dwdata", dWdata, d.data);
                end
                if (dmem_we) dmem[dAddr] = dWdata;
                else dRdata = dmem.exists(dAddr) ? dmem[dAddr] : 32'h0;
            end
        end else begin
            dmem_ready = 1'b0;
            dwait = 0;
        end
    endtask

    logic done = 1'b0;

    initial begin
        reset = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0;
        imem_rdata = '0; dRdata = '0;

        // gap = 4 per non-memory instruction, +1+DDly after a memory one, +fetch delay
        put(32'h100, enc_i(12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011), 0, 0, 1'b0);  // addi x1,x0,5
        put(32'h104, enc_j(21'd8, 5'd0), 0, 4, 1'b0);                           // jal x0,+8
        put(32'h10C, enc_s(12'd8, 5'd1, 5'd0), 0, 4, 1'b0);                     // sw x1,8(x0)
        exp_d(32'd8, 1'b1, 32'd5);
        put(32'h110, enc_b(13'h1ff8, 5'd0, 5'd0), 0, 7, 1'b0);                  // beq x0,x0,-8
        put(32'h108, enc_j(21'h10, 5'd0), 0, 4, 1'b0);                          // jal x0,+16
        put(32'h118, enc_i(12'd8, 5'd0, 3'b010, 5'd2, 7'b0000011), 3, 7, 1'b0); // lw x2,8(x0)
        exp_d(32'd8, 1'b0, 32'd0);
        put(32'h11C, enc_s(12'd12, 5'd2, 5'd0), 0, 7, 1'b0);                    // sw x2,12(x0)
        exp_d(32'd12, 1'b1, 32'd5);
        put(32'h120, enc_i(12'h200, 5'd0, 3'b000, 5'd1, 7'b0010011), 0, 7, 1'b0);
        put(32'h124, enc_i(12'd3, 5'd1, 3'b000, 5'd1, 7'b1100111), 0, 4, 1'b0);  // jalr x1,x1,3
        put(32'h202, enc_s(12'd16, 5'd1, 5'd0), 0, 4, 1'b0);                    // sw x1,16(x0)
        exp_d(32'd16, 1'b1, 32'h128);
        put(32'h206, enc_i(12'd7, 5'd0, 3'b000, 5'd0, 7'b0010011), 0, 7, 1'b0);  // addi x0,x0,7
        put(32'h20A, enc_s(12'd20, 5'd0, 5'd0), 0, 4, 1'b0);                    // sw x0,20(x0)
        exp_d(32'd20, 1'b1, 32'd0);
        put(32'h20E, enc_i(12'd1, 5'd0, 3'b000, 5'd20, 7'b0010011), 0, 7, 1'b0); // addi x20
        put(32'h212, enc_i(12'd8, 5'd0, 3'b010, 5'd3, 7'b0000011), 0, 4, 1'b1);  // lw x3

        repeat (2) @(negedge clk);
        check_eq("rst_imem_req", 32'(imem_req), 32'd0);
        check_eq("rst_dmem_req", 32'(dmem_req), 32'd0);
        check_eq("rst_dmem_we", 32'(dmem_we), 32'd0);
        check_eq("rst_illegal", 32'(illegal_reg), 32'd0);
        check_eq("rst_ir", instr_code, 32'd0);
        check_eq("rst_pc", instr_rAddr, RstPc);
        reset = 1'b0;

        // The final lw is interrupted by reset while it waits in MEM.
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            if (dmem_req && dq.size() == 0) done = 1'b1;
            else bus_step();
        end
        check_eq("program_reached_end", 32'(done), 32'd1);
        check_eq("fetch_queue_drained", fq.size(), 32'd0);

        reset = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0;
        @(negedge clk);
        check_eq("midmem_rst_dmem_req", 32'(dmem_req), 32'd0);
        check_eq("midmem_rst_imem_req", 32'(imem_req), 32'd0);
        check_eq("midmem_rst_illegal", 32'(illegal_reg), 32'd0);
        check_eq("midmem_rst_pc", instr_rAddr, RstPc);
        check_eq("midmem_rst_ir", instr_code, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check_eq("post_rst_fetch_req", 32'(imem_req), 32'd1);
        check_eq("post_rst_dmem_req", 32'(dmem_req), 32'd0);
        check_eq("post_rst_pc", instr_rAddr, RstPc);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mc_datapath.md
MC_DATAPATH -- requirements
Module: mc_datapath

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter NREGS, default 32: implemented GPR count; legal values 16 (RV32E) or 32.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset; synchronous, active-high.
REQ-005 alu_controls  input  4  ALU/branch op, codebase define.sv encodings.
REQ-006 reg_wr_en, aluSrcMuxSel, branch, jal, jalr, mem_rd, mem_wr  input  1 each  control-unit decodes of instr_code.
REQ-007 RegWdataSel  input  3  writeback select: 0 ALU, 1 load data, 2 imm, 3 target, 4 PC+4.
REQ-008 instr_code  output  32  instruction register (IR) contents, drives the control unit.
REQ-009 imem_req / imem_ready  output / input  1 / 1  instruction fetch handshake.
REQ-010 instr_rAddr  output  32  fetch address (current PC).
REQ-011 imem_rdata  input  32  fetched instruction.
REQ-012 dmem_req / dmem_ready  output / input  1 / 1  data access handshake.
REQ-013 dmem_we  output  1  1 = store, 0 = load; valid while dmem_req=1.
REQ-014 dAddr, dWdata  output  32 each  data address (ALUOut), store data (latched rs2).
REQ-015 dRdata  input  32  load data.
REQ-016 illegal_reg  output  1  sticky flag: register index >= NREGS was referenced.

Function
REQ-017 FSM states: FETCH, DECODE, EXEC, MEM, WB; exactly one active.
REQ-018 FETCH: imem_req=1; on imem_ready=1, IR<=imem_rdata, go DECODE; otherwise stay with instr_rAddr stable.
REQ-019 DECODE: latch A<=rs1, B<=rs2, IMM<=sign-extended immediate; go EXEC.
REQ-020 EXEC: ALUOut<=ALU(A, aluSrcMuxSel ? IMM : B); latch b_taken; go MEM if mem_rd|mem_wr, else WB.
REQ-021 MEM: dmem_req=1, dmem_we=mem_wr; dAddr/dWdata stable until dmem_ready=1; then MDR<=dRdata on load; go WB.
REQ-022 WB: write selected data to rd if reg_wr_en & rd!=0 & rd<NREGS; update PC; go FETCH.
REQ-023 PC update in WB: jal or (branch & b_taken) -> PC+IMM; jalr -> (A+IMM) & ~32'h1; otherwise PC+4; 32-bit wrap, no overflow detection.
REQ-024 A transfer occurs only in a cycle with req=1 and ready=1; req never deasserts before its transfer completes.
REQ-025 Latency with ready tied high: non-memory instruction 4 cycles, load/store 5 cycles.
REQ-026 x0 reads 0; writes to x0 are discarded.
REQ-027 rs1/rs2/rd index >= NREGS: read returns 0, write discarded, illegal_reg set and held until reset.
REQ-028 jalr result uses rs1 latched in DECODE, so rd==rs1 returns the correct old-value-based target.
REQ-029 Register file writes occur only in WB; no other state writes GPRs.

Reset
REQ-030 reset=1 at a clock edge: state<=FETCH, PC<=RESET_PC, IR<=0, illegal_reg<=0, from any state including mid-handshake.
REQ-031 While reset=1: imem_req=0, dmem_req=0, dmem_we=0; no GPR write.
REQ-032 GPR contents are not reset; x0 remains 0.
REQ-033 First fetch from RESET_PC in the first cycle after reset deasserts.

Configuration
REQ-034 Macro MC_PERF_CNT_EN defined: adds 64-bit outputs cycle_cnt (+1 every non-reset cycle) and instret_cnt (+1 on each WB exit), both reset to 0 and wrapping.
REQ-035 MC_PERF_CNT_EN undefined: counters and their ports absent; all other behaviour identical.

Verification
REQ-036 Reset, RESET_PC=32'h100, ready=1 -> first instr_rAddr=32'h100; addi x1,x0,5 -> x1=5 after 4 cycles, PC=32'h104.
REQ-037 imem_ready low 3 cycles in FETCH -> imem_req held, instr_rAddr stable, IR unchanged until the ready cycle.
REQ-038 sw x1,8(x0) then lw x2,8(x0), dmem_ready delayed 2 cycles -> dAddr=8, dWdata=5, dmem_we 1 then 0; x2=5.
REQ-039 beq x0,x0,-8 at 32'h110 -> next PC 32'h108; jalr x1,x1,3 with x1=32'h200 -> PC=32'h202, x1=old PC+4.
REQ-040 NREGS=16, addi x20,x0,1 -> no write, illegal_reg=1; reset asserted mid-MEM -> dmem_req=0 next cycle, state FETCH, illegal_reg=0.
